mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: fetch (0) vs data (1), round-robin on contention, timeout abort.
// Latency: request sampled in IDLE -> MemReq next cycle; MemReady -> AckX next cycle; >= 3 cycles/txn.
// Backpressure: requesters hold Req/Addr/WrEn/WrData until their AckX; new requests wait in IDLE.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req0,
  input  logic [31:0] Addr0,
  input  logic        Req1,
  input  logic [31:0] Addr1,
  input  logic        WrEn1,
  input  logic [31:0] WrData1,
  input  logic        MemReady,
  input  logic [31:0] MemRdData,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  output logic        MemWrEn,
  output logic [31:0] MemWrData,
  output logic        Sel,
  output logic        Ack0,
  output logic        Ack1,
  output logic [31:0] RdData,
  output logic        Err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // Last BUSY cycle value of the wait counter before the access is aborted.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_last_gnt;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic        r_mem_wr_en;
  logic [31:0] r_mem_wr_data;
  logic        r_sel;
  logic        r_ack0;
  logic        r_ack1;
  logic [31:0] r_rd_data;
  logic        r_err;

  logic        w_any_req;
  logic        w_both_req;
  logic        w_gnt;

  // Grant choice: on contention the requester that did not win last contention goes next.
  assign w_any_req  = Req0 | Req1;
  assign w_both_req = Req0 & Req1;
  assign w_gnt      = w_both_req ? ~r_last_gnt : Req1;

  // Arbiter FSM with all outputs registered; reset aborts any access without an ack.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_last_gnt    <= 1'b1;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_data <= '0;
      r_sel         <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_rd_data     <= '0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel         <= w_gnt;
            r_mem_addr    <= w_gnt ? Addr1 : Addr0;
            r_mem_wr_en   <= w_gnt & WrEn1;
            r_mem_wr_data <= w_gnt ? WrData1 : '0;
            r_cnt         <= '0;
            r_mem_req     <= 1'b1;
            if (w_both_req) begin
              r_last_gnt <= w_gnt;
            end
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (MemReady) begin
            // Completion beats the timeout even on the last allowed cycle.
            r_rd_data <= r_mem_wr_en ? '0 : MemRdData;
            r_err     <= 1'b0;
            r_ack0    <= ~r_sel;
            r_ack1    <= r_sel;
            r_mem_req <= 1'b0;
            r_state   <= S_ACK;
          end else if (r_cnt == CNT_LAST) begin
            r_rd_data <= '0;
            r_err     <= 1'b1;
            r_ack0    <= ~r_sel;
            r_ack1    <= r_sel;
            r_mem_req <= 1'b0;
            r_state   <= S_ACK;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_ACK: begin
          r_ack0      <= 1'b0;
          r_ack1      <= 1'b0;
          r_err       <= 1'b0;
          r_mem_wr_en <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign MemReq    = r_mem_req;
  assign MemAddr   = r_mem_addr;
  assign MemWrEn   = r_mem_wr_en;
  assign MemWrData = r_mem_wr_data;
  assign Sel       = r_sel;
  assign Ack0      = r_ack0;
  assign Ack1      = r_ack1;
  assign RdData    = r_rd_data;
  assign Err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized transactions vs a transaction-level model.
// Latency: drives inputs and samples outputs on the falling edge, one rising edge per step.
// Backpressure: requests are held until the expected ack cycle, then dropped or kept as the step dictates.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req0, Req1, WrEn1, MemReady;
  logic [31:0] Addr0, Addr1, WrData1, MemRdData;
  logic        MemReq, MemWrEn, Sel, Ack0, Ack1, Err;
  logic [31:0] MemAddr, MemWrData, RdData;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model state: who won the last contention and what the outputs should be holding.
  logic        m_last_gnt;
  logic [31:0] m_addr;
  logic [31:0] m_rd;
  logic        m_sel;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .Addr0(Addr0),
    .Req1(Req1), .Addr1(Addr1), .WrEn1(WrEn1), .WrData1(WrData1),
    .MemReady(MemReady), .MemRdData(MemRdData),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemWrData(MemWrData),
    .Sel(Sel), .Ack0(Ack0), .Ack1(Ack1), .RdData(RdData), .Err(Err)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not complete");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Outputs expected while nothing is in flight.
  task automatic chk_quiet(input string tag);
    chk({tag, ".memreq"}, {31'b0, MemReq}, 32'd0);
    chk({tag, ".ack0"},   {31'b0, Ack0},   32'd0);
    chk({tag, ".ack1"},   {31'b0, Ack1},   32'd0);
    chk({tag, ".err"},    {31'b0, Err},    32'd0);
    chk({tag, ".wren"},   {31'b0, MemWrEn}, 32'd0);
    chk({tag, ".rddata"}, RdData,  m_rd);
    chk({tag, ".addr"},   MemAddr, m_addr);
    chk({tag, ".sel"},    {31'b0, Sel}, {31'b0, m_sel});
  endtask

  // Idle gap with MemReady noise, which must be ignored outside BUSY.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      Req0 = 1'b0; Req1 = 1'b0;
      MemReady  = 1'($urandom_range(0, 1));
      MemRdData = $urandom;
      step();
      chk_quiet("idle");
    end
    MemReady = 1'b0;
  endtask

  // One transaction starting from an IDLE falling edge. MemReady arrives on BUSY cycle k
  // (k > TO means never, so the access times out after TO BUSY cycles).
  task automatic txn(input logic r0, input logic r1, input logic [31:0] a0, input logic [31:0] a1,
                     input logic we, input logic [31:0] wd, input int k, input logic [31:0] rdat,
                     input logic drop);
    logic        g;
    logic        e_we, e_err;
    logic [31:0] e_wd;
    int          nbusy;
    if (r0 && r1) begin
      g = ~m_last_gnt;
      m_last_gnt = g;
    end else begin
      g = r1;
    end
    m_sel  = g;
    m_addr = g ? a1 : a0;
    e_we   = g & we;
    e_wd   = g ? wd : 32'd0;
    e_err  = (k > TO);
    nbusy  = e_err ? TO : k;
    m_rd   = (e_err || e_we) ? 32'd0 : rdat;

    Req0 = r0; Req1 = r1; Addr0 = a0; Addr1 = a1; WrEn1 = we; WrData1 = wd;
    MemReady = 1'b0;
    step();
    for (int b = 1; b <= nbusy; b++) begin
      chk("busy.memreq", {31'b0, MemReq}, 32'd1);
      chk("busy.sel",    {31'b0, Sel},    {31'b0, g});
      chk("busy.addr",   MemAddr,         m_addr);
      chk("busy.wren",   {31'b0, MemWrEn}, {31'b0, e_we});
      chk("busy.wrdata", MemWrData,       e_wd);
      chk("busy.ack",    {30'b0, Ack1, Ack0}, 32'd0);
      MemReady  = (b == k);
      MemRdData = (b == k) ? rdat : $urandom;
      step();
    end
    chk("ack.memreq", {31'b0, MemReq}, 32'd0);
    chk("ack.ack0",   {31'b0, Ack0},   {31'b0, ~g});
    chk("ack.ack1",   {31'b0, Ack1},   {31'b0, g});
    chk("ack.err",    {31'b0, Err},    {31'b0, e_err});
    chk("ack.rddata", RdData,          m_rd);
    chk("ack.addr",   MemAddr,         m_addr);
    chk("ack.wren",   {31'b0, MemWrEn}, {31'b0, e_we});
    MemReady  = 1'($urandom_range(0, 1));
    MemRdData = $urandom;
    if (drop) begin
      Req0 = 1'b0; Req1 = 1'b0;
    end
    step();
    MemReady = 1'b0;
    chk_quiet("post");
  endtask

  initial begin
    Rst = 1'b0; Req0 = 1'b1; Req1 = 1'b1; Addr0 = 32'h1111_1111; Addr1 = 32'h2222_2222;
    WrEn1 = 1'b1; WrData1 = 32'h3333_3333; MemReady = 1'b1; MemRdData = 32'h4444_4444;
    m_last_gnt = 1'b1; m_addr = 32'd0; m_rd = 32'd0; m_sel = 1'b0;

    // Reset dominates even with every input active.
    repeat (3) begin
      step();
      chk_quiet("rst");
      chk("rst.wrdata", MemWrData, 32'd0);
    end

    // Release with no requests: ten quiet cycles.
    Req0 = 1'b0; Req1 = 1'b0; WrEn1 = 1'b0; MemReady = 1'b0;
    Rst = 1'b1;
    idle(10);

    // Fetch read answered on the 3rd BUSY cycle.
    txn(1'b1, 1'b0, 32'h0040_0010, 32'h0, 1'b0, 32'h0, 3, 32'h8C22_0004, 1'b1);
    idle(1);

    // Data write: read data must come back as zero.
    txn(1'b0, 1'b1, 32'h0, 32'h1001_0000, 1'b1, 32'hDEAD_BEEF, 1, 32'h5555_AAAA, 1'b1);
    idle(2);

    // Both requesting for four back-to-back transactions: grants alternate 0,1,0,1.
    for (int t = 0; t < 4; t++) begin
      txn(1'b1, 1'b1, 32'hA000_0000 + t, 32'hB000_0000 + t, 1'b0, 32'h0, 1,
          32'hC000_0000 + t, (t == 3));
      chk("rr.order", {31'b0, Sel}, t[0] ? 32'd1 : 32'd0);
    end

    // Timeout with MemReady never arriving, then ready on the last allowed cycle.
    txn(1'b0, 1'b1, 32'h0, 32'h0000_0BAD, 1'b0, 32'h0, TO + 1, 32'hFFFF_FFFF, 1'b1);
    txn(1'b0, 1'b1, 32'h0, 32'h0000_0600, 1'b0, 32'h0, TO, 32'h1234_5678, 1'b1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] rq;
      rq = 2'($urandom_range(1, 3));
      txn(rq[0], rq[1], $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
          $urandom_range(1, TO + 2), $urandom, 1'b1);
      idle($urandom_range(0, 2));
    end

    // Reset during the 2nd BUSY cycle of a fetch read: silent abort.
    Req0 = 1'b1; Req1 = 1'b0; Addr0 = 32'h0040_0100; MemReady = 1'b0;
    step();
    chk("abort.busy1", {31'b0, MemReq}, 32'd1);
    @(posedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    chk("abort.memreq_async", {31'b0, MemReq}, 32'd0);
    chk("abort.ack0", {31'b0, Ack0}, 32'd0);
    m_last_gnt = 1'b1; m_addr = 32'd0; m_rd = 32'd0; m_sel = 1'b0;
    @(negedge Clk);
    Req1 = 1'b1; Addr1 = 32'h0000_7777;
    repeat (2) begin
      step();
      chk_quiet("abort.hold");
    end
    Rst = 1'b1;
    // First grant after release goes to requester 0.
    txn(1'b1, 1'b1, 32'h0040_0100, 32'h0000_7777, 1'b0, 32'h0, 2, 32'h0BAD_F00D, 1'b1);
    chk("abort.first_gnt", {31'b0, Sel}, 32'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
